// File: rtl/pit_controller.sv
// Programmable interval timer: one-shot or auto-reload down-counter behind a
// four-register bus interface, with a pending flag, maskable IRQ, EXPIRE pulse and LED toggle.
module pit_controller #(
  parameter int WIDTH = 32
) (
  input  logic             CLOCK,
  input  logic             RST,
  input  logic             WE,
  input  logic [1:0]       ADDR,
  input  logic [WIDTH-1:0] WDATA,
  output logic [WIDTH-1:0] RDATA,
  output logic             IRQ,
  output logic             EXPIRE,
  output logic             LED
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic             en, en_nxt, ie, ie_nxt, reload, reload_nxt;
  logic             pend, pend_nxt, irq_nxt, expire_nxt, led_nxt;
  logic [WIDTH-1:0] period, period_nxt, count, count_nxt;
  logic             ctrl_wr, period_wr, status_wr, expiry;

  always_ff @(posedge CLOCK or negedge RST) begin
    if (!RST) begin
      state  <= IDLE;
      en     <= 1'b0;
      ie     <= 1'b0;
      reload <= 1'b0;
      period <= '0;
      pend   <= 1'b0;
      count  <= '0;
      IRQ    <= 1'b0;
      EXPIRE <= 1'b0;
      LED    <= 1'b0;
    end else begin
      state  <= state_nxt;
      en     <= en_nxt;
      ie     <= ie_nxt;
      reload <= reload_nxt;
      period <= period_nxt;
      pend   <= pend_nxt;
      count  <= count_nxt;
      IRQ    <= irq_nxt;
      EXPIRE <= expire_nxt;
      LED    <= led_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    en_nxt     = en;
    ie_nxt     = ie;
    reload_nxt = reload;
    period_nxt = period;
    pend_nxt   = pend;
    count_nxt  = count;
    expire_nxt = 1'b0;
    led_nxt    = LED;
    // IRQ follows the registered PEND/IE, so it lags either by one cycle
    irq_nxt    = pend & ie;

    ctrl_wr   = WE && (ADDR == 2'd0);
    period_wr = WE && (ADDR == 2'd1);
    status_wr = WE && (ADDR == 2'd2);
    // A CTRL write in the same cycle overrides (and suppresses) an expiry
    expiry    = (state == RUN) && (count == WIDTH'(1)) && !ctrl_wr;

    if (period_wr)
      period_nxt = WDATA;

    if (status_wr && WDATA[0])
      pend_nxt = 1'b0;

    if (state == RUN && !ctrl_wr) begin
      if (count > WIDTH'(1)) begin
        count_nxt = count - WIDTH'(1);
      end else if (expiry) begin
        expire_nxt = 1'b1;
        led_nxt    = ~LED;
        pend_nxt   = 1'b1;
        if (reload && period != '0) begin
          count_nxt = period;
        end else begin
          count_nxt = '0;
          en_nxt    = 1'b0;
          state_nxt = IDLE;
        end
      end else begin
        en_nxt    = 1'b0;
        state_nxt = IDLE;
      end
    end

    if (ctrl_wr) begin
      en_nxt     = WDATA[0];
      ie_nxt     = WDATA[1];
      reload_nxt = WDATA[2];
      if (WDATA[0]) begin
        // Load from the register value before any coincident PERIOD write
        count_nxt = period;
        state_nxt = (period != '0) ? RUN : IDLE;
      end else begin
        state_nxt = IDLE;
      end
    end
  end

  always_comb begin
    RDATA = '0;
    case (ADDR)
      2'd0: RDATA = {{(WIDTH-3){1'b0}}, reload, ie, en};
      2'd1: RDATA = period;
      2'd2: RDATA = {{(WIDTH-1){1'b0}}, pend};
      2'd3: RDATA = count;
      default: RDATA = '0;
    endcase
  end

endmodule

// File: tb/tb_pit_controller.sv
// Directed bench for pit_controller: a vector table for the auto-reload flow
// plus hand-written sequences for one-shot, restart, W1C races and reset.
module tb_pit_controller;

  localparam int WIDTH = 32;

  logic             CLOCK = 1'b0;
  logic             RST   = 1'b0;
  logic             WE    = 1'b0;
  logic [1:0]       ADDR  = 2'd0;
  logic [WIDTH-1:0] WDATA = '0;
  logic [WIDTH-1:0] RDATA;
  logic             IRQ, EXPIRE, LED;

  int n_chk  = 0;
  int n_fail = 0;

  pit_controller #(.WIDTH(WIDTH)) dut (
    .CLOCK(CLOCK), .RST(RST), .WE(WE), .ADDR(ADDR), .WDATA(WDATA),
    .RDATA(RDATA), .IRQ(IRQ), .EXPIRE(EXPIRE), .LED(LED)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;
    logic        expire;
    logic        led;
  } vec_t;

  vec_t tv[23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one bus cycle, then sample just after the rising edge
  task automatic step(input logic we, input logic [1:0] addr, input logic [31:0] wdata);
    @(negedge CLOCK);
    WE = we; ADDR = addr; WDATA = wdata;
    @(posedge CLOCK);
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLOCK);
    RST = 1'b0; WE = 1'b0; ADDR = 2'd3; WDATA = '0;
    @(negedge CLOCK);
    RST = 1'b1;
  endtask

  // Idle for n cycles; EXPIRE must be low except on the n-th
  task automatic expect_expire_after(input int n, input string name);
    for (int i = 1; i <= n; i++) begin
      step(1'b0, 2'd3, '0);
      chk($sformatf("%s cyc%0d expire", name, i), {31'b0, EXPIRE}, {31'b0, (i == n)});
    end
  endtask

  initial begin
    int n_exp;
    int n_cnt;

    // Auto-reload PERIOD=5 flow, W1C, IE masking and stop-with-freeze
    tv[0]  = '{1'b1, 2'd1, 32'd5, 32'd5, 1'b0, 1'b0, 1'b0};
    tv[1]  = '{1'b1, 2'd0, 32'd7, 32'd7, 1'b0, 1'b0, 1'b0};
    tv[2]  = '{1'b0, 2'd3, 32'd0, 32'd4, 1'b0, 1'b0, 1'b0};
    tv[3]  = '{1'b0, 2'd3, 32'd0, 32'd3, 1'b0, 1'b0, 1'b0};
    tv[4]  = '{1'b0, 2'd3, 32'd0, 32'd2, 1'b0, 1'b0, 1'b0};
    tv[5]  = '{1'b0, 2'd3, 32'd0, 32'd1, 1'b0, 1'b0, 1'b0};
    tv[6]  = '{1'b0, 2'd3, 32'd0, 32'd5, 1'b0, 1'b1, 1'b1};
    tv[7]  = '{1'b0, 2'd3, 32'd0, 32'd4, 1'b1, 1'b0, 1'b1};
    tv[8]  = '{1'b0, 2'd3, 32'd0, 32'd3, 1'b1, 1'b0, 1'b1};
    tv[9]  = '{1'b0, 2'd3, 32'd0, 32'd2, 1'b1, 1'b0, 1'b1};
    tv[10] = '{1'b0, 2'd3, 32'd0, 32'd1, 1'b1, 1'b0, 1'b1};
    tv[11] = '{1'b0, 2'd3, 32'd0, 32'd5, 1'b1, 1'b1, 1'b0};
    tv[12] = '{1'b0, 2'd2, 32'd0, 32'd1, 1'b1, 1'b0, 1'b0};
    tv[13] = '{1'b1, 2'd2, 32'd1, 32'd0, 1'b1, 1'b0, 1'b0};
    tv[14] = '{1'b0, 2'd2, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0};
    tv[15] = '{1'b0, 2'd3, 32'd0, 32'd1, 1'b0, 1'b0, 1'b0};
    tv[16] = '{1'b0, 2'd3, 32'd0, 32'd5, 1'b0, 1'b1, 1'b1};
    tv[17] = '{1'b0, 2'd2, 32'd0, 32'd1, 1'b1, 1'b0, 1'b1};
    tv[18] = '{1'b1, 2'd0, 32'd2, 32'd2, 1'b1, 1'b0, 1'b1};
    tv[19] = '{1'b0, 2'd3, 32'd0, 32'd4, 1'b1, 1'b0, 1'b1};
    tv[20] = '{1'b1, 2'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1};
    tv[21] = '{1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1};
    tv[22] = '{1'b0, 2'd2, 32'd0, 32'd1, 1'b0, 1'b0, 1'b1};

    // Reset state, sampled while RST is held low
    RST = 1'b0;
    repeat (2) @(posedge CLOCK);
    #1;
    for (int a = 0; a < 4; a++) begin
      ADDR = a[1:0];
      #1;
      chk($sformatf("reset rdata addr%0d", a), RDATA, 32'd0);
    end
    chk("reset irq", {31'b0, IRQ}, 32'd0);
    chk("reset expire", {31'b0, EXPIRE}, 32'd0);
    chk("reset led", {31'b0, LED}, 32'd0);
    @(negedge CLOCK);
    RST = 1'b1;

    for (int i = 0; i < 23; i++) begin
      step(tv[i].we, tv[i].addr, tv[i].wdata);
      chk($sformatf("tv%0d rdata", i), RDATA, tv[i].rdata);
      chk($sformatf("tv%0d irq", i), {31'b0, IRQ}, {31'b0, tv[i].irq});
      chk($sformatf("tv%0d expire", i), {31'b0, EXPIRE}, {31'b0, tv[i].expire});
      chk($sformatf("tv%0d led", i), {31'b0, LED}, {31'b0, tv[i].led});
    end

    // One-shot PERIOD=3
    do_reset();
    step(1'b1, 2'd1, 32'd3);
    step(1'b1, 2'd0, 32'd1);
    expect_expire_after(3, "oneshot");
    step(1'b0, 2'd0, '0);
    chk("oneshot ctrl", RDATA, 32'd0);
    step(1'b0, 2'd3, '0);
    chk("oneshot count", RDATA, 32'd0);
    step(1'b0, 2'd2, '0);
    chk("oneshot pend", RDATA, 32'd1);
    chk("oneshot irq", {31'b0, IRQ}, 32'd0);
    n_exp = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 2'd3, '0);
      n_exp += EXPIRE;
    end
    chk("oneshot no re-expiry", n_exp, 32'd0);

    // PERIOD rewritten mid-interval: 4 then 2, 2
    do_reset();
    step(1'b1, 2'd1, 32'd4);
    step(1'b1, 2'd0, 32'd5);
    step(1'b1, 2'd1, 32'd2);
    expect_expire_after(3, "reperiod 4");
    expect_expire_after(2, "reperiod 2a");
    expect_expire_after(2, "reperiod 2b");

    // Restart on the expiry cycle suppresses that expiry
    do_reset();
    step(1'b1, 2'd1, 32'd3);
    step(1'b1, 2'd0, 32'd5);
    step(1'b0, 2'd3, '0);
    step(1'b0, 2'd3, '0);
    step(1'b1, 2'd0, 32'd5);
    chk("restart suppress expire", {31'b0, EXPIRE}, 32'd0);
    expect_expire_after(3, "restart");

    // W1C on the expiry cycle: set wins; later W1C clears, IRQ drops a cycle after
    do_reset();
    step(1'b1, 2'd1, 32'd3);
    step(1'b1, 2'd0, 32'd7);
    step(1'b0, 2'd3, '0);
    step(1'b0, 2'd3, '0);
    step(1'b1, 2'd2, 32'd1);
    chk("race expire", {31'b0, EXPIRE}, 32'd1);
    chk("race pend", RDATA, 32'd1);
    step(1'b1, 2'd0, 32'd2);
    chk("race irq", {31'b0, IRQ}, 32'd1);
    step(1'b1, 2'd2, 32'd1);
    chk("w1c pend", RDATA, 32'd0);
    chk("w1c irq same cycle", {31'b0, IRQ}, 32'd1);
    step(1'b0, 2'd2, '0);
    chk("w1c irq next cycle", {31'b0, IRQ}, 32'd0);
    step(1'b1, 2'd2, 32'd0);
    chk("w1c zero no effect", RDATA, 32'd0);

    // PERIOD=0 with EN set never expires
    do_reset();
    step(1'b1, 2'd0, 32'd7);
    chk("zero period ctrl", RDATA, 32'd7);
    n_exp = 0;
    n_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 2'd3, '0);
      n_exp += EXPIRE;
      if (RDATA != 0) n_cnt++;
    end
    chk("zero period expiries", n_exp, 32'd0);
    chk("zero period nonzero count", n_cnt, 32'd0);

    // Asynchronous reset mid-count after one expiry
    do_reset();
    step(1'b1, 2'd1, 32'd5);
    step(1'b1, 2'd0, 32'd7);
    for (int i = 0; i < 8; i++) step(1'b0, 2'd3, '0);
    chk("prereset count", RDATA, 32'd2);
    chk("prereset led", {31'b0, LED}, 32'd1);
    chk("prereset irq", {31'b0, IRQ}, 32'd1);
    #2;
    RST = 1'b0;
    #1;
    chk("async reset count", RDATA, 32'd0);
    chk("async reset irq", {31'b0, IRQ}, 32'd0);
    chk("async reset led", {31'b0, LED}, 32'd0);
    chk("async reset expire", {31'b0, EXPIRE}, 32'd0);
    @(negedge CLOCK);
    WE = 1'b0;
    @(negedge CLOCK);
    RST = 1'b1;
    n_exp = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 2'd3, '0);
      n_exp += EXPIRE;
    end
    chk("post reset expiries", n_exp, 32'd0);
    chk("post reset count", RDATA, 32'd0);
    step(1'b1, 2'd3, 32'd9);
    chk("count write ignored", RDATA, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pit_controller.md
PIT_CONTROLLER -- requirements
Module: pit_controller

Interface
REQ-001 Parameter: WIDTH, 32, counter and period register width in bits (legal range 4..32).
REQ-002 Port: CLOCK  in  1  system clock; all state updates on rising edge.
REQ-003 Port: RST  in  1  reset, asynchronous, active-low; low clears all state immediately.
REQ-004 Port: WE  in  1  register write strobe, one write per cycle when high.
REQ-005 Port: ADDR  in  2  register select: 0=CTRL, 1=PERIOD, 2=STATUS, 3=COUNT.
REQ-006 Port: WDATA  in  WIDTH  write data.
REQ-007 Port: RDATA  out  WIDTH  read data for ADDR, combinational.
REQ-008 Port: IRQ  out  1  registered interrupt, level, equals PEND AND IE.
REQ-009 Port: EXPIRE  out  1  registered one-cycle pulse per timer expiry.
REQ-010 Port: LED  out  1  registered; toggles on every expiry.

Function
REQ-011 CTRL fields: bit0 EN (run), bit1 IE (interrupt enable), bit2 RELOAD (auto-reload); other bits read 0, writes ignored.
REQ-012 PERIOD: read/write, full WIDTH; a write while running takes effect only at the next load or reload.
REQ-013 STATUS: bit0 PEND; write with WDATA[0]=1 clears PEND; write with WDATA[0]=0 has no effect.
REQ-014 COUNT register: read-only current counter value; writes ignored.
REQ-015 State machine: IDLE and RUN.
REQ-016 IDLE -> RUN: CTRL write with WDATA[0]=1 and PERIOD != 0; COUNT <= PERIOD on that edge.
REQ-017 CTRL write with WDATA[0]=1 while PERIOD==0: EN reads 1, state stays IDLE, no expiry ever generated.
REQ-018 RUN: COUNT decrements by 1 per cycle while COUNT > 1.
REQ-019 Expiry: in RUN with COUNT==1; on that edge PEND<=1, EXPIRE<=1 for one cycle, LED inverts.
REQ-020 At expiry with RELOAD=1: COUNT<=PERIOD (current register value), stay RUN; interval is exactly PERIOD cycles between EXPIRE pulses.
REQ-021 At expiry with RELOAD=0: COUNT<=0, EN<=0, go IDLE (one-shot).
REQ-022 PERIOD==0 sampled at auto-reload: COUNT<=0, EN<=0, go IDLE.
REQ-023 CTRL write with WDATA[0]=0 in RUN: go IDLE on that edge, COUNT frozen at current value, no expiry.
REQ-024 CTRL write with WDATA[0]=1 while already RUN: COUNT restarts from PERIOD; a coincident expiry is suppressed.
REQ-025 Simultaneous expiry and STATUS W1C in same cycle: set wins, PEND=1.
REQ-026 IRQ updates one cycle after PEND or IE changes; clearing IE masks IRQ without clearing PEND.
REQ-027 Arithmetic unsigned; counter never wraps below 0 nor exceeds PERIOD.

Reset
REQ-028 RST low: state IDLE, CTRL=0, PERIOD=0, PEND=0, COUNT=0, IRQ=0, EXPIRE=0, LED=0.
REQ-029 RST asserted mid-count aborts the interval; no EXPIRE pulse is emitted during or after reset.
REQ-030 First write is accepted on the first rising edge after RST deasserts.

Verification
REQ-031 PERIOD=5, CTRL=0x7 -> EXPIRE pulses every 5 cycles, first 5 cycles after CTRL write; LED toggles each; IRQ=1 one cycle after first EXPIRE.
REQ-032 PERIOD=3, CTRL=0x1 (one-shot) -> single EXPIRE after 3 cycles, then CTRL reads 0x0, COUNT reads 0, IRQ stays 0, PEND=1.
REQ-033 Auto-reload PERIOD=4, write PERIOD=2 mid-interval -> current interval stays 4 cycles, following intervals 2 cycles.
REQ-034 STATUS write 0x1 in exact expiry cycle -> PEND reads 1 afterwards; a later STATUS write 0x1 -> PEND=0, IRQ=0 next cycle.
REQ-035 PERIOD=0, CTRL=0x7 -> CTRL reads 0x7, no EXPIRE for 100 cycles, COUNT=0.
REQ-036 RST low for 1 cycle with COUNT=2 in RUN -> all outputs 0 immediately, no EXPIRE afterwards until re-enabled.
